// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters.
// Each request is registered, presented to the ALU for one cycle, and the
// captured result is returned to the granted port. The interface is
// IDLE -> EXEC -> RESP, so at most one operation completes every three cycles.
//
// Build option ALU_ARB_RR_EN:
//   defined   - round-robin; after each grant, the other port gets priority.
//   undefined - fixed priority; port 0 wins whenever both ports request.
//
// state | meaning
// IDLE  | accept one request; ALU inputs keep the last operands
// EXEC  | ALU evaluates the registered op; result captured at end of cycle
// RESP  | rsp_valid to granted port until it asserts rsp_ready
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] aluresult,
  input  logic             zero,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             pri;
  logic             hs0, hs1;
  logic             rsp_taken;

`ifdef ALU_ARB_RR_EN
  logic pri_q, pri_d;

  assign pri = pri_q;

  // Priority flips to the port that was not just granted.
  always_comb begin
    pri_d = pri_q;
    if (hs0) begin
      pri_d = 1'b1;
    end else if (hs1) begin
      pri_d = 1'b0;
    end
  end

  // Round-robin priority register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end
`else
  assign pri = 1'b0;
`endif

  // Request acceptance: only in IDLE, priority port wins a collision.
  always_comb begin
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    if (state_q == IDLE) begin
      req_ready0 = !pri || !req_valid1;
      req_ready1 = pri || !req_valid0;
    end
  end

  assign hs0       = req_valid0 && req_ready0;
  assign hs1       = req_valid1 && req_ready1;
  assign rsp_taken = grant_q ? rsp_ready1 : rsp_ready0;

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs0) begin
          grant_d = 1'b0;
          op_d    = req_op0;
          a_d     = req_a0;
          b_d     = req_b0;
          state_d = EXEC;
        end else if (hs1) begin
          grant_d = 1'b1;
          op_d    = req_op1;
          a_d     = req_a1;
          b_d     = req_b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = aluresult;
        zero_d  = zero;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alucontrol = op_q;
  assign srca       = a_q;
  assign srcb       = b_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_valid0 = (state_q == RESP) && !grant_q;
  assign rsp_valid1 = (state_q == RESP) && grant_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule
